// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state encoding for the ALU operation sequencer.
package alu_seq_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND = 3'd0;
   localparam logic [OP_W-1:0] OP_OR  = 3'd1;
   localparam logic [OP_W-1:0] OP_ADD = 3'd2;
   localparam logic [OP_W-1:0] OP_SUB = 3'd3;
   localparam logic [OP_W-1:0] OP_MUL = 3'd4;
   localparam logic [OP_W-1:0] OP_DIV = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MUL_ITER = 3'd1,
      ST_DIV_ITER = 3'd2,
      ST_FIXUP    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on the {HI, LO} working register.
// The divide step is only built when ALU_OP_SEQUENCER_DIV_EN is defined.
module alu_muldiv_step #(
   parameter int W = 32
) (
`ifdef ALU_OP_SEQUENCER_DIV_EN
   input  logic           div_mode,
`endif
   input  logic [2*W-1:0] work,
   input  logic [W-1:0]   opnd,
   output logic [2*W-1:0] work_next
);

   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;

   // LO holds the remaining multiplier bits; the carry of HI+mcand shifts into HI's top bit.
   always_comb begin
      mul_sum  = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      mul_next = {mul_sum, work[W-1:1]};
   end

`ifdef ALU_OP_SEQUENCER_DIV_EN
   logic [2*W:0]   div_shift;
   logic [W:0]     div_trial;
   logic [2*W-1:0] div_next;

   // Remainder in HI, dividend bits shift out of LO while quotient bits shift in.
   always_comb begin
      div_shift = {work, 1'b0};
      div_trial = div_shift[2*W:W] - {1'b0, opnd};
      if (!div_trial[W]) begin
         div_next = {div_trial[W-1:0], div_shift[W-1:1], 1'b1};
      end else begin
         div_next = {div_shift[2*W-1:W], div_shift[W-1:0]};
      end
   end

   assign work_next = div_mode ? div_next : mul_next;
`else
   assign work_next = mul_next;
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: single-cycle logic/add/sub, iterative signed multiply and divide.
// Divide support is built only when ALU_OP_SEQUENCER_DIV_EN is defined; otherwise opcode 5 is illegal.
//
// state       | meaning
// ST_IDLE     | ready for a request
// ST_MUL_ITER | shift-add iterations on operand magnitudes
// ST_DIV_ITER | restoring-divide iterations on operand magnitudes
// ST_FIXUP    | apply sign corrections to the magnitude result
// ST_DONE     | response held until consumer accepts
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [OP_W-1:0]         req_op,
   input  logic [DATA_WIDTH-1:0]   req_a,
   input  logic [DATA_WIDTH-1:0]   req_b,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [2*DATA_WIDTH-1:0] resp_result,
   output logic                    resp_err,
   output logic                    busy
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(W + 1);

   state_t           state, state_nx;
   logic [2*W-1:0]   work;
   logic [2*W-1:0]   work_step;
   logic [2*W-1:0]   work_fixed;
   logic [W-1:0]     opnd;
   logic [CNT_W-1:0] count;
   logic             neg_q;
   logic             err;

   logic             accept;
   logic             is_mul;
   logic             is_div_iter;
   logic [W-1:0]     mag_a;
   logic [W-1:0]     mag_b;
   logic [2*W-1:0]   quick_res;
   logic             quick_err;

   assign accept = req_valid & req_ready;
   assign is_mul = (req_op == OP_MUL);
   assign mag_a  = req_a[W-1] ? -req_a : req_a;
   assign mag_b  = req_b[W-1] ? -req_b : req_b;

`ifdef ALU_OP_SEQUENCER_DIV_EN
   logic div_q;
   logic neg_r;
   assign is_div_iter = (req_op == OP_DIV) && (req_b != '0);
`else
   assign is_div_iter = 1'b0;
`endif

   always_comb begin
      quick_res = '0;
      quick_err = 1'b0;
      case (req_op)
         OP_AND: quick_res = {{W{1'b0}}, req_a & req_b};
         OP_OR:  quick_res = {{W{1'b0}}, req_a | req_b};
         OP_ADD: quick_res = {{W{1'b0}}, req_a + req_b};
         OP_SUB: quick_res = {{W{1'b0}}, req_a - req_b};
         OP_MUL: quick_res = '0;
`ifdef ALU_OP_SEQUENCER_DIV_EN
         // Only reached here for a zero divisor; nonzero divides take the iterative path.
         OP_DIV: begin
            quick_res = {req_a, {W{1'b1}}};
            quick_err = 1'b1;
         end
`endif
         default: quick_err = 1'b1;
      endcase
   end

   always_comb begin
`ifdef ALU_OP_SEQUENCER_DIV_EN
      if (div_q) begin
         work_fixed = {(neg_r ? -work[2*W-1:W] : work[2*W-1:W]),
                       (neg_q ? -work[W-1:0]   : work[W-1:0])};
      end else begin
         work_fixed = neg_q ? -work : work;
      end
`else
      work_fixed = neg_q ? -work : work;
`endif
   end

   alu_muldiv_step #(.W(W)) u_step (
`ifdef ALU_OP_SEQUENCER_DIV_EN
      .div_mode  (div_q),
`endif
      .work      (work),
      .opnd      (opnd),
      .work_next (work_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul)           state_nx = ST_MUL_ITER;
               else if (is_div_iter) state_nx = ST_DIV_ITER;
               else                  state_nx = ST_DONE;
            end
         end
         ST_MUL_ITER, ST_DIV_ITER: if (count == CNT_W'(1)) state_nx = ST_FIXUP;
         ST_FIXUP:                 state_nx = ST_DONE;
         ST_DONE:                  if (resp_ready) state_nx = ST_IDLE;
         default:                  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work  <= '0;
         opnd  <= '0;
         count <= '0;
         neg_q <= 1'b0;
         err   <= 1'b0;
`ifdef ALU_OP_SEQUENCER_DIV_EN
         div_q <= 1'b0;
         neg_r <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  err   <= quick_err;
                  neg_q <= req_a[W-1] ^ req_b[W-1];
`ifdef ALU_OP_SEQUENCER_DIV_EN
                  div_q <= is_div_iter;
                  neg_r <= req_a[W-1];
`endif
                  if (is_mul) begin
                     work  <= {{W{1'b0}}, mag_b};
                     opnd  <= mag_a;
                     count <= CNT_W'(W);
                  end else if (is_div_iter) begin
                     work  <= {{W{1'b0}}, mag_a};
                     opnd  <= mag_b;
                     count <= CNT_W'(W);
                  end else begin
                     work  <= quick_res;
                  end
               end
            end
            ST_MUL_ITER, ST_DIV_ITER: begin
               work  <= work_step;
               count <= count - CNT_W'(1);
            end
            ST_FIXUP: work <= work_fixed;
            default: ;
         endcase
      end
   end

   assign resp_valid  = (state == ST_DONE);
   assign resp_result = work;
   assign resp_err    = err;
   assign busy        = (state != ST_IDLE);
   assign req_ready   = (state == ST_IDLE) && rst_n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vector table, hand sequences, random ops vs. a model.
module tb_alu_op_sequencer;

   localparam int W         = 32;
   localparam int LAT_ITER  = W + 2;
   localparam int LAT_LIMIT = 100;
`ifdef ALU_OP_SEQUENCER_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          resp_valid;
   logic          resp_ready;
   logic [2*W-1:0] resp_result;
   logic          resp_err;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   alu_op_sequencer #(.DATA_WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_err    (resp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h want=%h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got=%0d want=%0d", name, got, exp);
      end
   endtask

   // Reference behaviour from the arithmetic rules, using 64-bit signed integers.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [63:0] r, output logic e, output int lat);
      longint sa, sb, q, m;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      r   = '0;
      e   = 1'b0;
      lat = 1;
      case (op)
         3'd0: r = {32'd0, a & b};
         3'd1: r = {32'd0, a | b};
         3'd2: r = {32'd0, a + b};
         3'd3: r = {32'd0, a - b};
         3'd4: begin
            r   = sa * sb;
            lat = LAT_ITER;
         end
         3'd5: begin
            if (!DIV_EN) e = 1'b1;
            else if (b == 32'd0) begin
               r = {a, 32'hFFFF_FFFF};
               e = 1'b1;
            end else begin
               q   = sa / sb;
               m   = sa % sb;
               r   = {m[31:0], q[31:0]};
               lat = LAT_ITER;
            end
         end
         default: e = 1'b1;
      endcase
   endfunction

   // Issue one request, measure latency, hold the response for 'hold' cycles, then accept it.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input logic [63:0] exp_res,
                         output logic [63:0] res, output logic err, output int lat);
      int guard;
      bit busy_ok;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      busy_ok   = 1'b1;
      @(negedge clk);
      while (!resp_valid && lat < LAT_LIMIT) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!busy) busy_ok = 1'b0;
      check_int({name, "_busy"}, int'(busy_ok), 1);
      res = resp_result;
      err = resp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check64({name, "_hold_result"}, resp_result, exp_res);
         check_int({name, "_hold_valid"}, int'(resp_valid), 1);
         check_int({name, "_hold_req_ready"}, int'(req_ready), 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask

   task automatic run_checked(input string name, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [63:0] exp_res,
                              input logic exp_err, input int exp_lat);
      logic [63:0] res;
      logic        err;
      int          lat;
      run_op(name, op, a, b, 0, exp_res, res, err, lat);
      check64({name, "_result"}, res, exp_res);
      check_int({name, "_err"}, int'(err), int'(exp_err));
      check_int({name, "_latency"}, lat, exp_lat);
   endtask

   initial begin
      logic [63:0] res;
      logic        err;
      int          lat;
      bit          saw_valid;
      logic [63:0] m_res;
      logic        m_err;
      int          m_lat;
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;
      logic [31:0] corner [4];

      vecs.push_back('{"and",      3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 64'h0000_0000_00F0_1234, 1'b0, 1});
      vecs.push_back('{"or",       3'd1, 32'hF0F0_0000, 32'h0000_000F, 64'h0000_0000_F0F0_000F, 1'b0, 1});
      vecs.push_back('{"add_wrap", 3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0,                   1'b0, 1});
      vecs.push_back('{"sub_wrap", 3'd3, 32'h0000_0000, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0, 1});
      vecs.push_back('{"mul_m3x7", 3'd4, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, LAT_ITER});
      vecs.push_back('{"mul_minx_m1", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, LAT_ITER});
      vecs.push_back('{"mul_minxmin", 3'd4, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, LAT_ITER});
      vecs.push_back('{"mul_zero", 3'd4, 32'h0000_0000, 32'hFFFF_FFFB, 64'h0,                   1'b0, LAT_ITER});
      vecs.push_back('{"illegal7", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0,                   1'b1, 1});
      vecs.push_back('{"illegal6", 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,                   1'b1, 1});
`ifdef ALU_OP_SEQUENCER_DIV_EN
      vecs.push_back('{"div_17_m5",  3'd5, 32'd17,         32'hFFFF_FFFB, 64'h0000_0002_FFFF_FFFD, 1'b0, LAT_ITER});
      vecs.push_back('{"div_m17_5",  3'd5, 32'hFFFF_FFEF,  32'd5,         64'hFFFF_FFFE_FFFF_FFFD, 1'b0, LAT_ITER});
      vecs.push_back('{"div_min_m1", 3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, LAT_ITER});
      vecs.push_back('{"div_by0",    3'd5, 32'd9,          32'd0,         64'h0000_0009_FFFF_FFFF, 1'b1, 1});
`else
      vecs.push_back('{"div_illegal", 3'd5, 32'd17,        32'hFFFF_FFFB, 64'h0,                   1'b1, 1});
      vecs.push_back('{"div0_illegal", 3'd5, 32'd9,        32'd0,         64'h0,                   1'b1, 1});
`endif

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;

      #12;
      check_int("rst_resp_valid", int'(resp_valid), 0);
      check64("rst_resp_result", resp_result, 64'h0);
      check_int("rst_resp_err", int'(resp_err), 0);
      check_int("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_int("post_rst_req_ready", int'(req_ready), 1);

      foreach (vecs[i])
         run_checked(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, vecs[i].lat);

      // Backpressure: response held stable while resp_ready is low.
      run_op("bp_add", 3'd2, 32'd5, 32'd7, 5, 64'd12, res, err, lat);
      check64("bp_add_result", res, 64'd12);
      check_int("bp_add_latency", lat, 1);
      check_int("bp_released_valid", int'(resp_valid), 0);
      check_int("bp_released_req_ready", int'(req_ready), 1);
      run_checked("after_bp_add", 3'd2, 32'd100, 32'd23, 64'd123, 1'b0, 1);

      // Reset in the middle of a multiply aborts it without a response.
      @(negedge clk);
      req_op    = 3'd4;
      req_a     = 32'hFFFF_FFFD;
      req_b     = 32'd7;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_int("mid_mul_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_int("midrst_resp_valid", int'(resp_valid), 0);
      check64("midrst_resp_result", resp_result, 64'h0);
      check_int("midrst_resp_err", int'(resp_err), 0);
      check_int("midrst_busy", int'(busy), 0);
      @(negedge clk);
      rst_n     = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < LAT_ITER + 4; i++) begin
         @(negedge clk);
         if (resp_valid) saw_valid = 1'b1;
      end
      check_int("midrst_no_response", int'(saw_valid), 0);
      run_checked("after_rst_add", 3'd2, 32'd5, 32'd7, 64'd12, 1'b0, 1);

      // Random operations against the reference model, biased toward corner operands.
      corner[0] = 32'h0000_0000;
      corner[1] = 32'h0000_0001;
      corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000;
      for (int n = 0; n < 40; n++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         r_b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         if (n % 8 == 0) r_op = 3'd4;
         if (n % 8 == 1) r_op = 3'd5;
         model(r_op, r_a, r_b, m_res, m_err, m_lat);
         run_checked($sformatf("rand%0d_op%0d", n, r_op), r_op, r_a, r_b, m_res, m_err, m_lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle ALU controller sitting between the CPU control unit and the ALU datapath.
- Accepts one operation request over a valid/ready handshake.
- Executes logical and add/sub ops in one cycle; sequences signed multiply and divide iteratively.
- Returns a 2*DATA_WIDTH result (HI = upper half, LO = lower half) over a valid/ready response handshake.

Parameters:
DATA_WIDTH, 32, operand width; result width is 2*DATA_WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request (high only in IDLE)
req_op  input  3  opcode from shared package
req_a  input  DATA_WIDTH  operand A / dividend / multiplicand
req_b  input  DATA_WIDTH  operand B / divisor / multiplier
resp_valid  output  1  result valid, held until accepted
resp_ready  input  1  consumer accepts result
resp_result  output  2*DATA_WIDTH  {HI, LO}
resp_err  output  1  illegal opcode or divide-by-zero; qualified by resp_valid
busy  output  1  state is not IDLE

Behaviour:
- Opcodes: AND=0, OR=1, ADD=2, SUB=3, MUL=4, DIV=5; 6 and 7 are illegal.
- Reset (async, rst_n=0):
  - state = IDLE; resp_valid = 0, resp_result = 0, resp_err = 0, busy = 0; req_ready = 1 once out of reset.
  - The iteration counter and all working registers clear to 0.
  - Reset mid-operation aborts it; no response is produced.
- States: IDLE, MUL_ITER, DIV_ITER, FIXUP, DONE.
- Accept: req_valid & req_ready on a rising edge. Operands and opcode are registered on that edge; inputs are don't-care afterwards.
- Latency is counted with the accepting edge as edge 1:
  - AND/OR/ADD/SUB/illegal/div-by-zero: IDLE -> DONE on edge 1; resp_valid visible after edge 1.
  - MUL/DIV: edge 1 loads operand magnitudes and records the result signs; counter = DATA_WIDTH. Then DATA_WIDTH iteration edges, then one FIXUP edge. resp_valid visible after edge DATA_WIDTH+2.
- Arithmetic and width rules:
  - AND/OR: LO = A&B or A|B; HI = 0.
  - ADD/SUB: LO = (A±B) mod 2^DATA_WIDTH; HI = 0; no flags.
  - MUL: signed. Shift-add on |A|, |B| yields a 2*DATA_WIDTH product; FIXUP negates it if sign(A) xor sign(B). The most-negative operand is handled via unsigned magnitude, so e.g. -2^31 * -1 = +2^31 in 64 bits.
  - DIV: signed restoring division on magnitudes.
    - LO = quotient, truncated toward zero.
    - HI = remainder, with the sign of the dividend.
    - FIXUP applies both sign corrections.
    - Most-negative / -1: LO = most-negative (wraps), HI = 0, resp_err = 0.
  - Divide-by-zero (B=0, op DIV): single cycle; LO = all ones, HI = A, resp_err = 1.
  - Illegal op: single cycle; result 0, resp_err = 1.
- DONE:
  - resp_valid = 1 and resp_result/resp_err stay stable until resp_valid & resp_ready.
  - On that edge: resp_valid drops and the state returns to IDLE. req_ready rises the following cycle (minimum one idle cycle between responses and the next accept).
  - resp_ready while not in DONE is ignored.
- busy = (state != IDLE). req_ready = (state == IDLE).
- Counter decrements once per ITER edge. ITER -> FIXUP when the counter reaches 1 before decrement; the counter never wraps.

Optional Feature:
ALU_OP_SEQUENCER_DIV_EN
- Defined: DIV_ITER state and divide datapath are built as described above.
- Undefined: opcode 5 is treated as illegal (single cycle, result 0, resp_err = 1). No divider logic is instantiated; the MUL path is unchanged.

Decomposition:
- Package alu_seq_pkg holds:
  - OP_W = 3.
  - Opcode localparams OP_AND..OP_DIV.
  - State encoding for IDLE, MUL_ITER, DIV_ITER, FIXUP, DONE.
- Sub-module alu_muldiv_step: combinational one-iteration step (shift-add for MUL, trial-subtract/restore for DIV) on the {HI, LO} working register.
- The sequencer owns the FSM, counter, sign tracking and handshakes.

Test Plan:
- AND A=32'hF0F0_1234, B=32'h0FF0_FFFF -> resp_valid after edge 1, result 64'h0000_0000_00F0_1234, err 0.
- MUL A=-3, B=7 -> resp_valid after edge 34 (DATA_WIDTH=32), result 64'hFFFF_FFFF_FFFF_FFEB, err 0; busy high throughout.
- DIV A=17, B=-5 (DIV_EN defined) -> after edge 34, HI=32'h0000_0002, LO=32'hFFFF_FFFD; DIV with B=0, A=9 -> after edge 1, HI=9, LO=32'hFFFF_FFFF, err 1.
- Backpressure: hold resp_ready=0 for 5 cycles after an ADD 5+7 -> resp_result stays 12, req_ready stays 0; assert resp_ready -> IDLE, next request accepted one cycle later.
- Reset mid-MUL: drop rst_n at iteration 10 -> all outputs 0 immediately, no response; a fresh ADD afterwards completes normally.
- Illegal op 7 -> after edge 1, result 0, err 1; without DIV_EN, op 5 behaves identically.
